// File: rtl/parking_pkg.sv
// parking_pkg: shared types and defaults for the car-park gate front end.
//   entry_state_t : entry barrier FSM states
//   exit_state_t  : exit barrier FSM states
//   DEF_*         : default values for the tunable timing parameters
//   max_int       : helper used to size the shared barrier timers
package parking_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_OPEN_TIMEOUT    = 200;
  localparam int DEF_CLOSE_CYCLES    = 8;

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_OPEN = 2'd1,
    E_DENY = 2'd2,
    E_HOLD = 2'd3
  } entry_state_t;

  typedef enum logic [1:0] {
    X_IDLE = 2'd0,
    X_OPEN = 2'd1,
    X_HOLD = 2'd2
  } exit_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: 2-flop synchroniser plus stability counter for one loop
// detector.
//   clk    : system clock, rising edge
//   reset  : synchronous, active-low
//   raw    : asynchronous, bouncy detector input
//   level  : debounced sensor level
//   rise   : one-cycle strobe in the cycle level goes 0 -> 1
//   fall   : one-cycle strobe in the cycle level goes 1 -> 0
// level only follows the synchronised input after DEBOUNCE_CYCLES
// consecutive samples that disagree with it; any agreeing sample restarts
// the count.
module sensor_debounce
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      rise    <= 1'b0;
      fall    <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // strobes are registered alongside level so they line up with it
        level <= sync_q2;
        rise  <= sync_q2;
        fall  <= ~sync_q2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: sensor/barrier front end for the car-park occupancy
// counter. Debounces both loop sensors, sequences the entry and exit
// barriers, and turns each completed passage into a car_in / car_out pulse.
//   clk              : system clock, rising edge
//   reset            : synchronous, active-low
//   entry_sensor_raw : entry loop detector (async, bouncy)
//   exit_sensor_raw  : exit loop detector (async, bouncy)
//   lot_full         : full flag from the occupancy counter
//   car_in / car_out : one-cycle passage pulses, never together
//   entry_gate_open  : entry barrier open command (registered)
//   exit_gate_open   : exit barrier open command (registered)
//   entry_denied     : lot-full indicator at the entry (registered)
// Build option PARK_GATE_STATS_EN adds deny_count[15:0] and
// timeout_count[15:0], both saturating.
//
// Entry FSM
//   state  | meaning
//   E_IDLE | barrier closed, waiting for a debounced rise
//   E_DENY | car waiting while lot is full, entry_denied shown
//   E_OPEN | barrier open, waiting for the car to clear the loop
//   E_HOLD | barrier held closed for CLOSE_CYCLES, rises ignored
// Exit FSM
//   state  | meaning
//   X_IDLE | barrier closed, waiting for a debounced rise
//   X_OPEN | barrier open, waiting for the car to clear the loop
//   X_HOLD | barrier held closed for CLOSE_CYCLES, rises ignored
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int OPEN_TIMEOUT    = DEF_OPEN_TIMEOUT,
  parameter int CLOSE_CYCLES    = DEF_CLOSE_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        entry_sensor_raw,
  input  logic        exit_sensor_raw,
  input  logic        lot_full,
  output logic        car_in,
  output logic        car_out,
  output logic        entry_gate_open,
  output logic        exit_gate_open,
  output logic        entry_denied
`ifdef PARK_GATE_STATS_EN
  ,
  output logic [15:0] deny_count,
  output logic [15:0] timeout_count
`endif
);

  localparam int TW = $clog2(max_int(OPEN_TIMEOUT, CLOSE_CYCLES));
  localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_TIMEOUT - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(CLOSE_CYCLES - 1);

  logic e_level, e_rise, e_fall;
  logic x_level_unused, x_rise, x_fall;

  entry_state_t  e_state;
  exit_state_t   x_state;
  logic [TW-1:0] e_tmr;
  logic [TW-1:0] x_tmr;
  logic          pend_in;

  logic e_req, e_timeout, e_deny_go;
  logic x_req, x_timeout;
  logic in_want, out_want;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_deb (
    .clk   (clk),
    .reset (reset),
    .raw   (entry_sensor_raw),
    .level (e_level),
    .rise  (e_rise),
    .fall  (e_fall)
  );

  // the exit side has no deny state, so it only needs the strobes
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_deb (
    .clk   (clk),
    .reset (reset),
    .raw   (exit_sensor_raw),
    .level (x_level_unused),
    .rise  (x_rise),
    .fall  (x_fall)
  );

  assign e_req     = (e_state == E_OPEN) && e_fall;
  assign e_timeout = (e_state == E_OPEN) && !e_fall && (e_tmr == OPEN_LAST);
  assign e_deny_go = (e_state == E_IDLE) && e_rise && lot_full;
  assign x_req     = (x_state == X_OPEN) && x_fall;
  assign x_timeout = (x_state == X_OPEN) && !x_fall && (x_tmr == OPEN_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_state         <= E_IDLE;
      e_tmr           <= '0;
      entry_gate_open <= 1'b0;
      entry_denied    <= 1'b0;
    end else begin
      entry_gate_open <= (e_state == E_OPEN);
      entry_denied    <= (e_state == E_DENY);
      case (e_state)
        E_IDLE: begin
          if (e_deny_go) begin
            e_state <= E_DENY;
          end else if (e_rise) begin
            e_state <= E_OPEN;
            e_tmr   <= '0;
          end
        end
        E_DENY: begin
          // a car still on the loop when space appears is admitted
          if (!e_level) begin
            e_state <= E_IDLE;
          end else if (!lot_full) begin
            e_state <= E_OPEN;
            e_tmr   <= '0;
          end
        end
        E_OPEN: begin
          if (e_req || e_timeout) begin
            e_state <= E_HOLD;
            e_tmr   <= '0;
          end else begin
            e_tmr <= e_tmr + 1'b1;
          end
        end
        E_HOLD: begin
          if (e_tmr == HOLD_LAST) begin
            e_state <= E_IDLE;
          end else begin
            e_tmr <= e_tmr + 1'b1;
          end
        end
        default: e_state <= E_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x_state        <= X_IDLE;
      x_tmr          <= '0;
      exit_gate_open <= 1'b0;
    end else begin
      exit_gate_open <= (x_state == X_OPEN);
      case (x_state)
        X_IDLE: begin
          if (x_rise) begin
            x_state <= X_OPEN;
            x_tmr   <= '0;
          end
        end
        X_OPEN: begin
          if (x_req || x_timeout) begin
            x_state <= X_HOLD;
            x_tmr   <= '0;
          end else begin
            x_tmr <= x_tmr + 1'b1;
          end
        end
        X_HOLD: begin
          if (x_tmr == HOLD_LAST) begin
            x_state <= X_IDLE;
          end else begin
            x_tmr <= x_tmr + 1'b1;
          end
        end
        default: x_state <= X_IDLE;
      endcase
    end
  end

  // Pulse arbiter. The pulse registers double as the pending flags: a
  // request is emitted in the cycle after it is made. Exit always wins a
  // collision, so only the entry side can ever have to wait, and then for
  // exactly one cycle.
  assign in_want  = pend_in | e_req;
  assign out_want = x_req;

  always_ff @(posedge clk) begin
    if (!reset) begin
      car_in  <= 1'b0;
      car_out <= 1'b0;
      pend_in <= 1'b0;
    end else begin
      car_out <= out_want;
      car_in  <= in_want && !out_want;
      pend_in <= in_want && out_want;
    end
  end

`ifdef PARK_GATE_STATS_EN
  logic [16:0] timeout_sum;

  assign timeout_sum = {1'b0, timeout_count} + {16'd0, e_timeout} + {16'd0, x_timeout};

  always_ff @(posedge clk) begin
    if (!reset) begin
      deny_count    <= '0;
      timeout_count <= '0;
    end else begin
      if (e_deny_go && (deny_count != 16'hFFFF)) begin
        deny_count <= deny_count + 16'd1;
      end
      timeout_count <= timeout_sum[16] ? 16'hFFFF : timeout_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: directed scenarios for parking_gate_ctrl with
// default parameters (DEBOUNCE_CYCLES=4, OPEN_TIMEOUT=200, CLOSE_CYCLES=8).
// Inputs change 1 time unit after a rising edge; "after edge k" of a
// scenario is sampled in loop iteration c = k-1.
module tb_parking_gate_ctrl;
  import parking_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic entry_sensor_raw;
  logic exit_sensor_raw;
  logic lot_full;
  logic car_in;
  logic car_out;
  logic entry_gate_open;
  logic exit_gate_open;
  logic entry_denied;
`ifdef PARK_GATE_STATS_EN
  logic [15:0] deny_count;
  logic [15:0] timeout_count;
`endif

  parking_gate_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .entry_sensor_raw (entry_sensor_raw),
    .exit_sensor_raw  (exit_sensor_raw),
    .lot_full         (lot_full),
    .car_in           (car_in),
    .car_out          (car_out),
    .entry_gate_open  (entry_gate_open),
    .exit_gate_open   (exit_gate_open),
    .entry_denied     (entry_denied)
`ifdef PARK_GATE_STATS_EN
    ,
    .deny_count       (deny_count),
    .timeout_count    (timeout_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int ge_cnt, ge_first, ge_rises;
  int xg_cnt, xg_first;
  int den_cnt, den_first;
  int cin_cnt, cin_c;
  int cout_cnt, cout_c;
  int both_cnt;
  logic ge_prev;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    ge_cnt = 0; ge_first = -1; ge_rises = 0; ge_prev = 1'b0;
    xg_cnt = 0; xg_first = -1;
    den_cnt = 0; den_first = -1;
    cin_cnt = 0; cin_c = -1;
    cout_cnt = 0; cout_c = -1;
    both_cnt = 0;
  endtask

  task automatic observe(input int c);
    if (entry_gate_open === 1'b1) begin
      if (ge_first < 0) ge_first = c;
      ge_cnt++;
      if (!ge_prev) ge_rises++;
    end
    ge_prev = (entry_gate_open === 1'b1);
    if (exit_gate_open === 1'b1) begin
      if (xg_first < 0) xg_first = c;
      xg_cnt++;
    end
    if (entry_denied === 1'b1) begin
      if (den_first < 0) den_first = c;
      den_cnt++;
    end
    if (car_in === 1'b1) begin cin_cnt++; cin_c = c; end
    if (car_out === 1'b1) begin cout_cnt++; cout_c = c; end
    if (car_in === 1'b1 && car_out === 1'b1) both_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    entry_sensor_raw = 1'b0;
    exit_sensor_raw = 1'b0;
    lot_full = 1'b0;
    step();
    step();
    vectors++;
    if ({car_in, car_out, entry_gate_open, exit_gate_open, entry_denied} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {car_in, car_out, entry_gate_open, exit_gate_open, entry_denied});
    end
    vectors++;
    if (dut.e_state !== E_IDLE || dut.x_state !== X_IDLE) begin
      miscompares++;
      $display("FAIL reset_states: got entry %0d exit %0d expected 0 0", dut.e_state, dut.x_state);
    end
`ifdef PARK_GATE_STATS_EN
    vectors++;
    if (deny_count !== 16'd0 || timeout_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_stats: got %0d/%0d expected 0/0", deny_count, timeout_count);
    end
`endif
    reset = 1'b1;
    step();
  endtask

  // bouncy entry, one passage, then a second rise that lands in the
  // last hold cycle and must be ignored
  task automatic test_entry_passage();
    clear_obs();
    for (int c = 0; c < 60; c++) begin
      entry_sensor_raw = (c == 0) || (c == 2) || (c >= 4 && c < 20) || (c >= 28 && c < 46);
      step();
      observe(c);
    end
    entry_sensor_raw = 1'b0;
    vectors++;
    if (ge_first !== 11) begin
      miscompares++; $display("FAIL entry_gate_first: got %0d expected 11", ge_first);
    end
    vectors++;
    if (ge_cnt !== 16) begin
      miscompares++; $display("FAIL entry_gate_cycles: got %0d expected 16", ge_cnt);
    end
    vectors++;
    if (ge_rises !== 1) begin
      miscompares++; $display("FAIL entry_gate_openings: got %0d expected 1", ge_rises);
    end
    vectors++;
    if (cin_cnt !== 1 || cin_c !== 26) begin
      miscompares++; $display("FAIL entry_car_in: got %0d pulses at %0d expected 1 at 26", cin_cnt, cin_c);
    end
    vectors++;
    if (cout_cnt !== 0 || den_cnt !== 0) begin
      miscompares++; $display("FAIL entry_side_effects: got car_out %0d denied %0d expected 0 0", cout_cnt, den_cnt);
    end
  endtask

  task automatic test_full_lot();
    clear_obs();
    for (int c = 0; c < 50; c++) begin
      lot_full = (c < 20);
      entry_sensor_raw = (c < 30);
      step();
      observe(c);
    end
    entry_sensor_raw = 1'b0;
    lot_full = 1'b0;
    vectors++;
    if (den_first !== 7 || den_cnt !== 14) begin
      miscompares++; $display("FAIL full_denied: got first %0d cycles %0d expected 7 14", den_first, den_cnt);
    end
    vectors++;
    if (ge_first !== 21 || ge_cnt !== 16) begin
      miscompares++; $display("FAIL full_gate: got first %0d cycles %0d expected 21 16", ge_first, ge_cnt);
    end
    vectors++;
    if (cin_cnt !== 1 || cin_c !== 36) begin
      miscompares++; $display("FAIL full_car_in: got %0d pulses at %0d expected 1 at 36", cin_cnt, cin_c);
    end
`ifdef PARK_GATE_STATS_EN
    vectors++;
    if (deny_count !== 16'd1) begin
      miscompares++; $display("FAIL full_deny_count: got %0d expected 1", deny_count);
    end
`endif
  endtask

  task automatic test_timeout();
    clear_obs();
    for (int c = 0; c < 320; c++) begin
      exit_sensor_raw = (c < 300);
      step();
      observe(c);
    end
    exit_sensor_raw = 1'b0;
    vectors++;
    if (xg_first !== 7 || xg_cnt !== 200) begin
      miscompares++; $display("FAIL timeout_gate: got first %0d cycles %0d expected 7 200", xg_first, xg_cnt);
    end
    vectors++;
    if (cout_cnt !== 0 || cin_cnt !== 0) begin
      miscompares++; $display("FAIL timeout_pulses: got car_out %0d car_in %0d expected 0 0", cout_cnt, cin_cnt);
    end
`ifdef PARK_GATE_STATS_EN
    vectors++;
    if (timeout_count !== 16'd1) begin
      miscompares++; $display("FAIL timeout_count: got %0d expected 1", timeout_count);
    end
`endif
  endtask

  task automatic test_collision();
    clear_obs();
    for (int c = 0; c < 45; c++) begin
      entry_sensor_raw = (c < 20);
      exit_sensor_raw = (c < 20);
      step();
      observe(c);
    end
    vectors++;
    if (cout_cnt !== 1 || cout_c !== 26) begin
      miscompares++; $display("FAIL collision_car_out: got %0d pulses at %0d expected 1 at 26", cout_cnt, cout_c);
    end
    vectors++;
    if (cin_cnt !== 1 || cin_c !== 27) begin
      miscompares++; $display("FAIL collision_car_in: got %0d pulses at %0d expected 1 at 27", cin_cnt, cin_c);
    end
    vectors++;
    if (both_cnt !== 0) begin
      miscompares++; $display("FAIL collision_overlap: got %0d expected 0", both_cnt);
    end
  endtask

  task automatic test_glitch();
    clear_obs();
    for (int c = 0; c < 30; c++) begin
      entry_sensor_raw = (c < 3) || (c >= 10 && c < 13);
      exit_sensor_raw = (c < 3) || (c >= 10 && c < 13);
      step();
      observe(c);
    end
    vectors++;
    if (ge_cnt !== 0 || xg_cnt !== 0) begin
      miscompares++; $display("FAIL glitch_gates: got entry %0d exit %0d expected 0 0", ge_cnt, xg_cnt);
    end
    vectors++;
    if (cin_cnt !== 0 || cout_cnt !== 0) begin
      miscompares++; $display("FAIL glitch_pulses: got car_in %0d car_out %0d expected 0 0", cin_cnt, cout_cnt);
    end
  endtask

  // four stable samples is the shortest pulse that counts as a passage
  task automatic test_min_pulse();
    clear_obs();
    for (int c = 0; c < 25; c++) begin
      entry_sensor_raw = (c < 4);
      step();
      observe(c);
    end
    vectors++;
    if (ge_first !== 7 || ge_cnt !== 4) begin
      miscompares++; $display("FAIL min_pulse_gate: got first %0d cycles %0d expected 7 4", ge_first, ge_cnt);
    end
    vectors++;
    if (cin_cnt !== 1 || cin_c !== 10) begin
      miscompares++; $display("FAIL min_pulse_car_in: got %0d pulses at %0d expected 1 at 10", cin_cnt, cin_c);
    end
  endtask

  // reset lands when car_out is being emitted and car_in is still waiting
  task automatic test_reset_mid();
    clear_obs();
    for (int c = 0; c < 28; c++) begin
      entry_sensor_raw = (c < 20);
      exit_sensor_raw = (c < 20);
      if (c == 27) reset = 1'b0;
      step();
      if (c == 26) begin
        vectors++;
        if (entry_gate_open !== 1'b1 || car_out !== 1'b1 || dut.pend_in !== 1'b1) begin
          miscompares++;
          $display("FAIL reset_mid_setup: got gate %b car_out %b pend %b expected 1 1 1",
                   entry_gate_open, car_out, dut.pend_in);
        end
      end
    end
    vectors++;
    if ({car_in, car_out, entry_gate_open, exit_gate_open, entry_denied} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got %b expected 00000",
               {car_in, car_out, entry_gate_open, exit_gate_open, entry_denied});
    end
    vectors++;
    if (dut.e_state !== E_IDLE || dut.pend_in !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_state: got state %0d pend %b expected 0 0", dut.e_state, dut.pend_in);
    end
`ifdef PARK_GATE_STATS_EN
    vectors++;
    if (deny_count !== 16'd0 || timeout_count !== 16'd0) begin
      miscompares++; $display("FAIL reset_mid_stats: got %0d/%0d expected 0/0", deny_count, timeout_count);
    end
`endif
    reset = 1'b1;
    clear_obs();
    for (int c = 0; c < 20; c++) begin
      step();
      observe(c);
    end
    vectors++;
    if (cin_cnt !== 0 || cout_cnt !== 0 || ge_cnt !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_after: got car_in %0d car_out %0d gate %0d expected 0 0 0",
               cin_cnt, cout_cnt, ge_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_entry_passage();
    test_full_lot();
    test_timeout();
    test_collision();
    test_glitch();
    test_min_pulse();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
- Sensor/barrier front end for the car-park occupancy counter.
- Debounces the raw entry and exit loop sensors and sequences the entry and exit barriers.
- Turns each completed passage into a single-cycle car_in or car_out pulse for the counter.
- Uses the counter's full flag to refuse entry. car_in and car_out are never asserted in the same cycle, because the counter ignores simultaneous events.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable raw samples required before the debounced sensor changes (min 1).
- OPEN_TIMEOUT, 200: cycles a barrier stays open waiting for passage before it aborts (min 2).
- CLOSE_CYCLES, 8: cycles the barrier is held closed after passage or abort before a new request is accepted (min 2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- entry_sensor_raw  input  1  entry loop detector, asynchronous to clk, bouncy.
- exit_sensor_raw  input  1  exit loop detector, asynchronous to clk, bouncy.
- lot_full  input  1  full flag from the occupancy counter.
- car_in  output  1  one-cycle pulse: one car has entered.
- car_out  output  1  one-cycle pulse: one car has left.
- entry_gate_open  output  1  entry barrier open command.
- exit_gate_open  output  1  exit barrier open command.
- entry_denied  output  1  "lot full" indicator at the entry.

Behaviour:
- Reset (reset==0 at a clk edge): every output is 0, both FSMs are in IDLE, debounced sensors are 0, sync flops are 0, timers and pending flags are cleared. Reset mid-passage drops the barrier and loses any pending pulse.
- Sensor input path:
  - Each raw sensor goes through a 2-flop synchroniser, then the debouncer.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronised samples differ from it.
  - The rise/fall strobe is one cycle, in the cycle the level changes.
- Entry FSM states: E_IDLE, E_OPEN, E_DENY, E_HOLD.
  - E_IDLE: acts on the debounced rise only, never on a steady-high level.
    - Rise with lot_full==1: go to E_DENY.
    - Rise with lot_full==0: go to E_OPEN.
  - E_DENY: entry_denied=1.
    - Debounced sensor low: go to E_IDLE.
    - Sensor still high and lot_full drops to 0: go to E_OPEN. The waiting car is admitted.
  - E_OPEN: entry_gate_open=1, timer counts from 0.
    - Debounced fall (car passed): request car_in, go to E_HOLD.
    - Timer reaches OPEN_TIMEOUT-1 with no fall: go to E_HOLD with no request.
  - E_HOLD: barrier closed for CLOSE_CYCLES cycles, then E_IDLE. Rises seen during E_HOLD are ignored.
- Exit FSM states: X_IDLE, X_OPEN, X_HOLD.
  - Same as the entry FSM with no full check and no deny state.
  - It requests car_out instead of car_in.
- Gate outputs are registered. They assert the cycle after the FSM enters OPEN and deassert the cycle after it leaves OPEN.
- Pulse arbiter:
  - Each request sets its own pending flag. A pulse is emitted the cycle after the request.
  - If both flags are set in the same cycle, car_out is emitted first and car_in the following cycle. Exit first frees space.
  - Never more than one pulse per cycle. A flag clears when its pulse is emitted.
  - Per direction, at most one request can be pending, since CLOSE_CYCLES≥2.
- Timers are sized with $clog2 of the larger of OPEN_TIMEOUT and CLOSE_CYCLES. They never wrap; each stops at its terminal count.

Optional Feature:
- Macro: PARK_GATE_STATS_EN.
- Defined: adds output ports deny_count[15:0] and timeout_count[15:0].
  - deny_count increments on each E_IDLE→E_DENY transition.
  - timeout_count increments on each entry or exit OPEN→HOLD transition caused by timeout. Simultaneous entry and exit timeouts add 2.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: neither the ports nor the counters exist. All other behaviour is identical.

Decomposition:
- Shared package parking_pkg holds:
  - the entry FSM state typedef (E_IDLE, E_OPEN, E_DENY, E_HOLD);
  - the exit FSM state typedef (X_IDLE, X_OPEN, X_HOLD);
  - default parameter constants.
- One sub-module: sensor_debounce (synchroniser + debounce counter + rise/fall strobes), instantiated twice.
- FSMs, timers and the arbiter stay in parking_gate_ctrl.

Test Plan:
- Entry passage:
  - Stimulus: lot_full=0; entry raw high for 20 cycles with 3 bounces in the first 3 cycles, then low.
  - Response: exactly one debounced rise; entry_gate_open high until the debounced fall; exactly one car_in pulse; then 8 closed cycles; no car_out.
- Full lot:
  - Stimulus: lot_full=1, entry raw high.
  - Response: entry_denied=1 and the gate stays closed.
  - Then drop lot_full while the sensor is still high: gate opens and, after passage, exactly one car_in.
- Timeout:
  - Stimulus: exit raw held high for 300 cycles.
  - Response: exit_gate_open is high for 200 cycles then drops; no car_out. With PARK_GATE_STATS_EN, timeout_count=1.
- Collision:
  - Stimulus: entry and exit debounced falls in the same cycle.
  - Response: car_out in cycle N+1, car_in in cycle N+2, never both high together.
- Glitch rejection:
  - Stimulus: raw pulses 3 cycles wide, DEBOUNCE_CYCLES=4.
  - Response: no gate opens and no pulses.
- Reset mid-operation:
  - Stimulus: reset=0 for one cycle while entry_gate_open=1 and a car_in is pending.
  - Response: all outputs 0 the next cycle, no car_in emitted, FSM in E_IDLE.
